// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, with a fixed
// programmable wait between request accept and response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               commit_c;
  logic               t_we;
  logic [31:0]        t_addr, t_wdata, t_off;
  logic [3:0]         t_be;
  logic               t_err;
  logic [IDX_W-1:0]   t_idx;

  // Transaction being committed: live request when LATENCY=0 commits straight from IDLE.
  always_comb begin
    t_we    = we_q;
    t_addr  = addr_q;
    t_wdata = wdata_q;
    t_be    = be_q;
    if (state_q == S_IDLE) begin
      t_we    = req_we;
      t_addr  = req_addr;
      t_wdata = req_wdata;
      t_be    = req_be;
    end
    t_off = t_addr - BASE_ADDR;
    t_err = (t_addr[1:0] != 2'b00) || (t_off >= SPAN_BYTES);
    t_idx = t_off[IDX_W+1:2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          req_ready_d = 1'b0;
          if (LATENCY == 0) begin
            commit_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) commit_c = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Response payload is captured on the edge that enters RESP and held until handshake.
    if (commit_c) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = t_err;
      rsp_rdata_d = (t_we || t_err) ? '0 : mem_q[t_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is not reset; a store only lands on its commit edge.
  always_ff @(posedge clk) begin
    if (rst_n && commit_c && t_we && !t_err) begin
      for (int i = 0; i < 4; i++) begin
        if (t_be[i]) mem_q[t_idx][8*i +: 8] <= t_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=0 and a LATENCY=2 instance checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0), .BASE_ADDR(32'h1000_0000)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDR(32'h0)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h1000_0000 : 32'h0;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: busy from accept until response handshake; the
  // response (and any store) takes effect LATENCY edges after accept.
  bit          m_busy [2];
  bit          m_resp [2];
  int          m_left [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  logic [31:0] mem_m [2][64];

  task automatic model_commit(input int k);
    logic [31:0] off;
    off = m_addr[k] - base_of(k);
    m_err[k] = (m_addr[k][1:0] != 2'b00) || (off >= 32'd256);
    m_rdata[k] = 32'h0;
    if (!m_err[k]) begin
      if (m_we[k]) begin
        for (int b = 0; b < 4; b++)
          if (m_be[k][b]) mem_m[k][off[7:2]][8*b +: 8] = m_wdata[k][8*b +: 8];
      end else begin
        m_rdata[k] = mem_m[k][off[7:2]];
      end
    end
    m_resp[k] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_resp[k] = 1'b0;
        m_left[k] = 0;
      end else if (!m_busy[k]) begin
        if (req_valid[k]) begin
          m_busy[k]  = 1'b1;
          m_we[k]    = req_we[k];
          m_addr[k]  = req_addr[k];
          m_wdata[k] = req_wdata[k];
          m_be[k]    = req_be[k];
          m_left[k]  = lat_of(k);
          if (m_left[k] == 0) model_commit(k);
        end
      end else if (!m_resp[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) model_commit(k);
      end else if (rsp_ready[k]) begin
        m_busy[k] = 1'b0;
        m_resp[k] = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("req_ready", k, 32'(req_ready[k]), 32'(!m_busy[k]));
      chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_resp[k]));
      if (m_resp[k]) begin
        chk("rsp_rdata", k, rsp_rdata[k], m_rdata[k]);
        chk("rsp_err", k, 32'(rsp_err[k]), 32'(m_err[k]));
      end else if (!rst_n) begin
        chk("rst_rdata", k, rsp_rdata[k], 32'h0);
        chk("rst_err", k, 32'(rsp_err[k]), 32'h0);
      end
    end
  end

  task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    rsp_ready[k] = (hold == 0);
    @(posedge clk); #1;
    // While busy, keep a conflicting store on the bus: it must be ignored.
    req_valid[k] = (hold > 0);
    req_we[k]    = 1'b1;
    req_wdata[k] = 32'h0BAD_0BAD;
    req_be[k]    = 4'hF;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("rsp_timeout", k, 32'(lat >= 40), 32'h0);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    for (int i = 0; i < hold; i++) begin
      chk("bp_req_ready", k, 32'(req_ready[k]), 32'h0);
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int k);
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    a = base_of(k) + 32'($urandom_range(0, 63) * 4);
    if (r == 0)      a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = base_of(k) + 32'd256 + 32'($urandom_range(0, 15) * 4);
    else if (r == 2) a = base_of(k) - 32'd4;
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          cnt;

    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_be[k] = '0;   rsp_ready[k] = 1'b0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", k, 32'(req_ready[k]), 32'h1);
      chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'h0);
      chk("reset_rdata", k, rsp_rdata[k], 32'h0);
      chk("reset_err", k, 32'(rsp_err[k]), 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill every word so the model knows the whole array.
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++)
        txn(k, 1'b1, base_of(k) + 32'(w * 4), $urandom, 4'hF, 0, rd, er, lat);

    txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    chk("store_latency", 1, 32'(lat), 32'd3);
    chk("store_err", 1, 32'(er), 32'h0);
    chk("store_rdata", 1, rd, 32'h0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("load_after_store", 1, rd, 32'hDEAD_BEEF);

    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    chk("bp_rdata", 1, rd, 32'hDEAD_BEEF);
    chk("bp_err", 1, 32'(er), 32'h0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("bp_ignored_store", 1, rd, 32'hDEAD_BEEF);

    txn(1, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("byte_enable_merge", 1, rd, 32'hDE22_BE44);

    txn(1, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    txn(1, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
    chk("misaligned_err", 1, 32'(er), 32'h1);
    chk("misaligned_rdata", 1, rd, 32'h0);
    txn(1, 1'b1, 32'h100, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    chk("range_err", 1, 32'(er), 32'h1);
    chk("range_latency", 1, 32'(lat), 32'd3);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    chk("word0_unchanged", 1, rd, 32'hCAFE_F00D);

    txn(0, 1'b1, 32'h1000_0008, 32'hA5A5_0001, 4'hF, 0, rd, er, lat);
    chk("lat0_latency", 0, 32'(lat), 32'd1);
    txn(0, 1'b0, 32'h1000_0008, 32'h0, 4'h0, 0, rd, er, lat);
    chk("lat0_load", 0, rd, 32'hA5A5_0001);
    txn(0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, rd, er, lat);
    chk("lat0_below_base_err", 0, 32'(er), 32'h1);

    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h1000_0008; rsp_ready[0] = 1'b1;
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (rsp_valid[0]) cnt++; end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
    chk("lat0_throughput", 0, 32'(cnt), 32'd10);
    @(posedge clk); #1;

    txn(1, 1'b1, 32'h20, 32'h5, 4'hF, 0, rd, er, lat);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h99; req_be[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_req_ready", 1, 32'(req_ready[1]), 32'h1);
    chk("midreset_rsp_valid", 1, 32'(rsp_valid[1]), 32'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("dropped_store", 1, rd, 32'h5);

    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = rand_addr(k);
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom_range(0, 15));
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
